// File: rtl/peripheral_uart_fifo.sv
//==============================================================================
// Module      : peripheral_uart_fifo
// Description : Bus-mapped full-duplex UART with TX/RX FIFOs, programmable
//               baud divisor, sticky overrun/framing flags and an interrupt.
//               Register map: 0 = data, 1 = status/flag clear, 2 = divisor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module peripheral_uart_fifo #(
   parameter int DATA_W      = 8,     // 5..8 data bits, LSB first
   parameter int DIV_W       = 16,    // at most 16 (bus width)
   parameter int DIV_DEFAULT = 434,
   parameter int TX_AW       = 4,
   parameter int RX_AW       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [1:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] c_DIV_MIN  = DIV_W'(4);
   localparam logic [DIV_W-1:0] c_DIV_RST  = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
   localparam logic [2:0]       c_LAST_BIT = 3'(DATA_W - 1);
   localparam logic [TX_AW:0]   c_TX_P1    = (TX_AW+1)'(1);
   localparam logic [RX_AW:0]   c_RX_P1    = (RX_AW+1)'(1);

   // ---------------------------------------------------------------- bus
   logic r_rd_q, r_wr_q;
   logic w_rd_req, w_wr_req, w_rd_fire, w_wr_fire;

   assign w_rd_req  = cs & rd;
   assign w_wr_req  = cs & wr;
   assign w_wr_fire = w_wr_req & ~r_wr_q;
   assign w_rd_fire = w_rd_req & ~r_rd_q & ~w_wr_req;   // write wins

   // Previous strobe levels so a held strobe acts only on its first cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_q <= 1'b0;
         r_wr_q <= 1'b0;
      end else begin
         r_rd_q <= w_rd_req;
         r_wr_q <= w_wr_req;
      end
   end

   // ---------------------------------------------------------------- divisor / flags
   logic [DIV_W-1:0] r_div, w_div_wr;
   logic             r_ovr, r_ferr, w_ovr_set, w_ferr_set, w_ovr_clr, w_ferr_clr;

   assign w_div_wr   = d_in[DIV_W-1:0];
   assign w_ovr_clr  = w_wr_fire && (addr == 2'd1) && d_in[3];
   assign w_ferr_clr = w_wr_fire && (addr == 2'd1) && d_in[4];

   // Divisor register (clamped to a usable minimum) and sticky error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div  <= c_DIV_RST;
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         if (w_wr_fire && (addr == 2'd2))
            r_div <= (w_div_wr < c_DIV_MIN) ? c_DIV_MIN : w_div_wr;
         if (w_ovr_set)       r_ovr <= 1'b1;
         else if (w_ovr_clr)  r_ovr <= 1'b0;
         if (w_ferr_set)      r_ferr <= 1'b1;
         else if (w_ferr_clr) r_ferr <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- TX FIFO
   logic [DATA_W-1:0] r_tx_mem [2**TX_AW];
   logic [TX_AW:0]    r_tx_wp, r_tx_rp;
   logic              w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;

   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign w_tx_full  = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                       (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);
   assign w_tx_push  = w_wr_fire && (addr == 2'd0) && !w_tx_full;

   // TX storage array, written on accepted bus pushes
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= d_in[DATA_W-1:0];
   end

   // TX FIFO pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_wp <= '0;
         r_tx_rp <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + c_TX_P1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_TX_P1;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   state_t            r_tx_state, w_tx_state_nx;
   logic [DIV_W-1:0]  r_tx_cnt, w_tx_cnt_nx, r_tx_div, w_tx_div_nx;
   logic [2:0]        r_tx_bit, w_tx_bit_nx;
   logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nx;
   logic              r_tx_line, w_tx_line_nx, w_tx_start, w_tx_end;

   assign w_tx_end = (r_tx_cnt == r_tx_div - c_DIV_ONE);
   assign w_tx_pop = w_tx_start;
   assign uart_tx  = r_tx_line;

   // TX state register; the line is registered so it never glitches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_div   <= c_DIV_RST;
         r_tx_bit   <= '0;
         r_tx_sh    <= '0;
         r_tx_line  <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nx;
         r_tx_cnt   <= w_tx_cnt_nx;
         r_tx_div   <= w_tx_div_nx;
         r_tx_bit   <= w_tx_bit_nx;
         r_tx_sh    <= w_tx_sh_nx;
         r_tx_line  <= w_tx_line_nx;
      end
   end

   // TX next state; a queued byte starts straight out of STOP with no idle gap
   always_comb begin
      w_tx_state_nx = r_tx_state;
      w_tx_cnt_nx   = r_tx_cnt + c_DIV_ONE;
      w_tx_div_nx   = r_tx_div;
      w_tx_bit_nx   = r_tx_bit;
      w_tx_sh_nx    = r_tx_sh;
      w_tx_start    = 1'b0;
      case (r_tx_state)
         S_IDLE: begin
            w_tx_cnt_nx = '0;
            w_tx_start  = !w_tx_empty;
         end
         S_START: if (w_tx_end) begin
            w_tx_cnt_nx   = '0;
            w_tx_bit_nx   = '0;
            w_tx_state_nx = S_DATA;
         end
         S_DATA: if (w_tx_end) begin
            w_tx_cnt_nx = '0;
            w_tx_sh_nx  = r_tx_sh >> 1;
            if (r_tx_bit == c_LAST_BIT) w_tx_state_nx = S_STOP;
            else                        w_tx_bit_nx   = r_tx_bit + 3'd1;
         end
         default: if (w_tx_end) begin
            w_tx_cnt_nx   = '0;
            w_tx_state_nx = S_IDLE;
            w_tx_start    = !w_tx_empty;
         end
      endcase
      if (w_tx_start) begin
         w_tx_state_nx = S_START;
         w_tx_cnt_nx   = '0;
         w_tx_div_nx   = r_div;
         w_tx_sh_nx    = r_tx_mem[r_tx_rp[TX_AW-1:0]];
      end
      case (w_tx_state_nx)
         S_START: w_tx_line_nx = 1'b0;
         S_DATA:  w_tx_line_nx = w_tx_sh_nx[0];
         default: w_tx_line_nx = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------- RX sync
   logic r_rx_s1, r_rx_s2, r_rx_prev;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= uart_rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   // ---------------------------------------------------------------- RX FSM
   state_t            r_rx_state, w_rx_state_nx;
   logic [DIV_W-1:0]  r_rx_cnt, w_rx_cnt_nx, r_rx_div, w_rx_div_nx;
   logic [2:0]        r_rx_bit, w_rx_bit_nx;
   logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nx;
   logic              w_rx_store, w_rx_end;

   assign w_rx_end = (r_rx_cnt == r_rx_div - c_DIV_ONE);

   // RX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_div   <= c_DIV_RST;
         r_rx_bit   <= '0;
         r_rx_sh    <= '0;
      end else begin
         r_rx_state <= w_rx_state_nx;
         r_rx_cnt   <= w_rx_cnt_nx;
         r_rx_div   <= w_rx_div_nx;
         r_rx_bit   <= w_rx_bit_nx;
         r_rx_sh    <= w_rx_sh_nx;
      end
   end

   // RX next state: half-bit start qualification, then one sample per bit
   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_rx_cnt_nx   = r_rx_cnt + c_DIV_ONE;
      w_rx_div_nx   = r_rx_div;
      w_rx_bit_nx   = r_rx_bit;
      w_rx_sh_nx    = r_rx_sh;
      w_rx_store    = 1'b0;
      w_ferr_set    = 1'b0;
      case (r_rx_state)
         S_IDLE: begin
            w_rx_cnt_nx = '0;
            if (r_rx_prev && !r_rx_s2) begin
               w_rx_state_nx = S_START;
               w_rx_div_nx   = r_div;
            end
         end
         S_START: if (r_rx_cnt == (r_rx_div >> 1) - c_DIV_ONE) begin
            w_rx_cnt_nx   = '0;
            w_rx_bit_nx   = '0;
            w_rx_state_nx = r_rx_s2 ? S_IDLE : S_DATA;
         end
         S_DATA: if (w_rx_end) begin
            w_rx_cnt_nx = '0;
            w_rx_sh_nx  = {r_rx_s2, r_rx_sh[DATA_W-1:1]};
            if (r_rx_bit == c_LAST_BIT) w_rx_state_nx = S_STOP;
            else                        w_rx_bit_nx   = r_rx_bit + 3'd1;
         end
         default: if (w_rx_end) begin
            w_rx_cnt_nx   = '0;
            w_rx_state_nx = S_IDLE;
            w_rx_store    = r_rx_s2;
            w_ferr_set    = !r_rx_s2;
         end
      endcase
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [DATA_W-1:0] r_rx_mem [2**RX_AW];
   logic [RX_AW:0]    r_rx_wp, r_rx_rp;
   logic              w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

   assign w_rx_empty = (r_rx_wp == r_rx_rp);
   assign w_rx_full  = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                       (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);
   assign w_rx_push  = w_rx_store && !w_rx_full;
   assign w_ovr_set  = w_rx_store && w_rx_full;
   assign w_rx_pop   = w_rd_fire && (addr == 2'd0) && !w_rx_empty;

   // RX storage array, written when a good frame completes
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= r_rx_sh;
   end

   // RX FIFO pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_wp <= '0;
         r_rx_rp <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + c_RX_P1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_RX_P1;
      end
   end

   // ---------------------------------------------------------------- read path
   logic [15:0] w_rd_data;

   // Read data mux for the addressed register
   always_comb begin
      w_rd_data = '0;
      case (addr)
         2'd0: if (!w_rx_empty) begin
            w_rd_data[DATA_W-1:0] = r_rx_mem[r_rx_rp[RX_AW-1:0]];
            w_rd_data[15]         = 1'b1;
         end
         2'd1:    w_rd_data[4:0] = {r_ferr, r_ovr, w_tx_full, w_tx_empty, w_rx_empty};
         2'd2:    w_rd_data = 16'(r_div);
         default: w_rd_data = '0;
      endcase
   end

   // d_out captures on a firing read and holds until the next one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           d_out <= '0;
      else if (w_rd_fire) d_out <= w_rd_data;
   end

   assign irq = ~w_rx_empty | r_ovr | r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_uart_fifo.sv
//==============================================================================
// Module      : tb_peripheral_uart_fifo
// Description : Directed self-checking bench for peripheral_uart_fifo.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_peripheral_uart_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] d_in;
   logic        cs;
   logic [1:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;
   logic        uart_rx;
   logic        uart_tx;
   logic        irq;

   logic        rx_drv;
   logic        lb;
   assign uart_rx = lb ? uart_tx : rx_drv;

   int n_checks = 0;
   int n_pass   = 0;

   // TX line monitor: counts falling edges and the length of the first low run
   bit mon_en = 1'b0;
   bit first_done;
   logic mon_prev = 1'b1;
   int fe_cnt, low_run;

   always #5 clk = ~clk;

   peripheral_uart_fifo #(
      .DATA_W(8), .DIV_W(16), .DIV_DEFAULT(434), .TX_AW(4), .RX_AW(4)
   ) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
      .d_out(d_out), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
   );

   always @(negedge clk) begin
      if (mon_en) begin
         if (mon_prev && !uart_tx) fe_cnt++;
         if (fe_cnt == 1 && !first_done) begin
            if (!uart_tx) low_run++;
            else          first_done = 1'b1;
         end
      end
      mon_prev = uart_tx;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      @(negedge clk); cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [15:0] q);
      @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk); cs = 1'b0; rd = 1'b0; q = d_out;
   endtask

   // Drive one frame at 8 clocks per bit on the RX line
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         repeat (8) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      logic [15:0] q;
      logic [9:0]  frame, cap;
      int          k, errs, good;

      rst = 1'b0; d_in = '0; cs = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
      rx_drv = 1'b1; lb = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_uart_tx", 32'(uart_tx), 1);
      check("rst_d_out",   32'(d_out), 0);
      check("rst_irq",     32'(irq), 0);
      rst = 1'b1;
      bus_rd(2'd1, q); check("rst_status", 32'(q), 'h0003);
      bus_rd(2'd2, q); check("rst_div",    32'(q), 434);

      // divisor write and a single TX frame of 0x55
      bus_wr(2'd2, 16'd8);
      bus_rd(2'd2, q); check("div_readback", 32'(q), 8);
      bus_wr(2'd0, 16'h0055);
      k = 0;
      while (uart_tx !== 1'b0 && k < 4) begin
         @(negedge clk);
         k++;
      end
      check("tx_start_latency_ok", 32'(k >= 1 && k <= 2), 1);
      frame = {1'b1, 8'h55, 1'b0};
      errs = 0;
      cap  = '0;
      for (int j = 0; j < 80; j++) begin
         if (j > 0) @(negedge clk);
         if (uart_tx !== frame[j/8]) errs++;
         if (j % 8 == 4) cap[j/8] = uart_tx;
      end
      check("tx_frame_cells", 32'(errs), 0);
      check("tx_frame_bits",  32'(cap), 32'(frame));
      @(negedge clk); check("tx_idle_after", 32'(uart_tx), 1);
      bus_rd(2'd1, q); check("tx_status_empty", 32'(q), 'h0003);

      // loopback of two bytes
      lb = 1'b1;
      bus_wr(2'd0, 16'h00A5);
      bus_wr(2'd0, 16'h003C);
      idle(220);
      check("lb_irq", 32'(irq), 1);
      bus_rd(2'd0, q); check("lb_byte0", 32'(q), 'h80A5);
      bus_rd(2'd0, q); check("lb_byte1", 32'(q), 'h803C);
      bus_rd(2'd0, q); check("lb_empty", 32'(q), 'h0000);
      check("lb_irq_clear", 32'(irq), 0);
      lb = 1'b0;

      // RX overrun: 17 frames into a 16-entry FIFO
      for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
      idle(10);
      bus_rd(2'd1, q); check("ovr_status", 32'(q), 'h000A);
      check("ovr_irq", 32'(irq), 1);
      bus_wr(2'd1, 16'h0008);
      bus_rd(2'd1, q); check("ovr_cleared", 32'(q), 'h0002);
      good = 0;
      for (int i = 0; i < 16; i++) begin
         bus_rd(2'd0, q);
         if (q == 16'h8010 + 16'(i)) good++;
      end
      check("ovr_fifo_bytes", 32'(good), 16);
      bus_rd(2'd0, q); check("ovr_fifo_empty", 32'(q), 0);

      // framing error, then a short glitch
      send_frame(8'h12, 1'b0);
      idle(10);
      bus_rd(2'd1, q); check("ferr_status", 32'(q), 'h0013);
      check("ferr_irq", 32'(irq), 1);
      bus_wr(2'd1, 16'h0010);
      bus_rd(2'd1, q); check("ferr_cleared", 32'(q), 'h0003);
      @(negedge clk); rx_drv = 1'b0;
      repeat (2) @(negedge clk); rx_drv = 1'b1;
      idle(100);
      bus_rd(2'd1, q); check("glitch_status", 32'(q), 'h0003);
      check("glitch_irq", 32'(irq), 0);

      // held read strobe pops only once
      send_frame(8'h21, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(20);
      @(negedge clk); cs = 1'b1; rd = 1'b1; addr = 2'd0;
      repeat (5) @(negedge clk);
      check("held_rd_data", 32'(d_out), 'h8021);
      cs = 1'b0; rd = 1'b0;
      bus_rd(2'd0, q); check("held_next",  32'(q), 'h8022);
      bus_rd(2'd0, q); check("held_empty", 32'(q), 0);

      // TX fill at divisor 434; divisor drops to 8 while frame 1 is in flight
      bus_wr(2'd2, 16'd434);
      fe_cnt = 0; low_run = 0; first_done = 1'b0; mon_en = 1'b1;
      for (int i = 0; i < 20; i++) bus_wr(2'd0, 16'h00FF);
      bus_rd(2'd1, q); check("txfull_status", 32'(q), 'h0005);
      bus_wr(2'd2, 16'd8);
      idle(6500);
      check("txfull_frames",      32'(fe_cnt), 17);
      check("txfull_first_start", 32'(low_run), 434);
      bus_rd(2'd1, q); check("txfull_drained", 32'(q), 'h0003);
      mon_en = 1'b0;

      // divisor writes below 4 are clamped
      bus_wr(2'd2, 16'd1);
      bus_rd(2'd2, q); check("div_clamp", 32'(q), 4);
      bus_wr(2'd2, 16'd8);

      // reset asserted mid-frame
      bus_wr(2'd0, 16'h0000);
      idle(10);
      check("pre_rst_line_low", 32'(uart_tx), 0);
      rst = 1'b0;
      #1;
      check("async_rst_tx", 32'(uart_tx), 1);
      @(negedge clk); rst = 1'b1;
      bus_rd(2'd2, q); check("post_rst_div", 32'(q), 434);
      idle(100);
      check("post_rst_line", 32'(uart_tx), 1);
      bus_rd(2'd1, q); check("post_rst_status", 32'(q), 'h0003);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/peripheral_uart_fifo.md
Name: peripheral_uart_fifo

Overview:
- Parametrised successor to the single-byte serial peripheral on the J1 bus.
- Full-duplex 8N1-style UART (configurable data width) with independent TX and RX FIFOs.
- Runtime-programmable baud divisor; status, error flags and an interrupt line.
- Sits on the 16-bit CPU peripheral bus (cs/addr/rd/wr) and drives the external Bluetooth/serial module pins.

Parameters:
DATA_W, 8, data bits per frame (5..8), LSB first.
DIV_W, 16, width of the baud divisor register.
DIV_DEFAULT, 434, clocks per bit after reset (50 MHz / 115200).
TX_AW, 4, log2 of TX FIFO depth (16 entries).
RX_AW, 4, log2 of RX FIFO depth (16 entries).

Ports:
clk  in  1  system clock, single domain.
rst  in  1  asynchronous, active-low reset.
d_in  in  16  bus write data.
cs  in  1  chip select.
addr  in  2  register select.
rd  in  1  read strobe.
wr  in  1  write strobe.
d_out  out  16  registered bus read data.
uart_rx  in  1  serial input, asynchronous to clk.
uart_tx  out  1  serial output, idle high.
irq  out  1  high while RX FIFO is non-empty, or while overrun/framing flag is set.

Behaviour:
- Reset values (rst low, asynchronous): uart_tx=1, d_out=0, irq=0. Both FIFOs empty, all flags 0, divisor=DIV_DEFAULT, TX/RX FSMs IDLE.
- Bus strobes are edge-qualified. An access fires only on the first cycle of cs&rd (or cs&wr); holding the strobe does not repeat the action. If rd and wr are both high, wr wins and no read side effect occurs.
- d_out updates on the clock after the firing read cycle and holds until the next read.
- addr 0, write: push d_in[DATA_W-1:0] into the TX FIFO. Dropped if the FIFO is full (no flag).
- addr 0, read: d_out={bit15=valid, zeros, data}, then pop. When empty, d_out=0 and no pop.
- addr 1, read: d_out={11'b0, ferr, ovr, tx_full, tx_empty, rx_empty} (bits 4..0).
- addr 1, write: d_in[3]=1 clears ovr; d_in[4]=1 clears ferr.
- addr 2: divisor, read/write, zero-extended to 16 bits. Values below 4 are stored as 4. A new divisor takes effect at the next TX/RX frame start, never mid-frame.
- addr 3: reads 0; writes are ignored.
- FIFOs: circular buffers with pointers one bit wider than the address. Full when the MSBs differ and the rest are equal. Push and pop in the same cycle both take effect and the count is unchanged. Push on full is ignored.
- TX FSM:
  - IDLE: if the FIFO is not empty, pop and go to START.
  - START: drive 0 for div clocks.
  - DATA: DATA_W bits, LSB first, div clocks each.
  - STOP: drive 1 for div clocks, then back to IDLE.
  - Back-to-back frames follow with no extra idle gap.
- RX synchroniser: two-flop synchroniser on uart_rx.
- RX FSM:
  - IDLE: a synced falling edge moves to START.
  - START: wait div/2 clocks (integer floor). If the line is low, go to DATA; otherwise it is a glitch, return to IDLE.
  - DATA: sample every div clocks, DATA_W bits.
  - STOP: sample after div clocks. A 1 pushes the byte; if the RX FIFO is full, the byte is discarded and ovr is set. A 0 discards the byte and sets ferr.
  - In every case, return to IDLE once the stop sample is taken.
- Flags: ovr and ferr are sticky until cleared. Setting a flag takes priority over clearing it in the same cycle.
- rst asserted mid-frame: uart_tx goes to 1 immediately and any partial frame is lost.

Test Plan:
- Reset: hold rst=0 for 3 clks -> uart_tx=1, d_out=0, irq=0; read addr1 -> 0x0003; read addr2 -> 434.
- Divisor and TX: write addr2=8, then addr0=0x55 -> uart_tx low after at most 2 clks. Frame of 80 clks = start 0, bits 1,0,1,0,1,0,1,0, stop 1. tx_empty=1 after the pop.
- Loopback with fill: tie uart_tx to uart_rx, write 0xA5, 0x3C -> both received in order. irq=1. Reads of addr0 return 0x80A5 then 0x803C, then 0x0000.
- RX overrun: with div=8, inject 17 valid frames without reading -> 16 bytes stored, status bit3=1, irq=1. Write addr1=0x0008 -> bit3=0; the FIFO still holds 16 bytes.
- Framing error and glitch: inject a frame 0x12 with stop=0 -> ferr=1 and the FIFO stays empty. Inject a 2-clk low pulse -> nothing received and no flag.
- Held strobe and full TX: hold cs&rd on addr0 for 5 clks with 2 bytes queued -> exactly one pop. Write 20 bytes quickly with divisor 434 -> tx_full=1 and 17 frames are emitted in total (first popped immediately + 16 queued); the extra writes are dropped.
